// File: rtl/stim_pkg.sv
// rtl/stim_pkg.sv - shared types, constants and helpers for the stimulus driver / MISR block
package stim_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } stim_state_e;

    localparam int STIM_DATA_W  = 96;
    localparam int STIM_CLKIN_W = 160;
    localparam int STIM_LFSR_W  = 32;

    localparam logic [STIM_LFSR_W-1:0] STIM_XOR_MASK     = 32'hA5A5A5A5;
    localparam logic [STIM_LFSR_W-1:0] STIM_POLY_DEFAULT = 32'h80200003;

    // One LFSR word fans out to the whole DUT input bus.
    function automatic logic [STIM_DATA_W-1:0] stim_expand(input logic [STIM_LFSR_W-1:0] lfsr);
        return {lfsr, lfsr ^ STIM_XOR_MASK, ~lfsr};
    endfunction

    function automatic logic [STIM_LFSR_W-1:0] stim_lfsr_next(input logic [STIM_LFSR_W-1:0] lfsr,
                                                             input logic [STIM_LFSR_W-1:0] poly);
        return lfsr[0] ? ((lfsr >> 1) ^ poly) : (lfsr >> 1);
    endfunction

endpackage

// File: rtl/stim_drive_misr_misr96.sv
// rtl/stim_drive_misr_misr96.sv - 96-bit rotate-and-XOR signature register (probe input with STIM_PROBE_EN)
module misr96
    import stim_pkg::*;
(
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   clr_i,
    input  logic                   en_i,
    input  logic [STIM_DATA_W-1:0] data_i,
`ifdef STIM_PROBE_EN
    input  logic [31:0]            probe_i,
`endif
    output logic [STIM_DATA_W-1:0] sig_o
);

    logic [STIM_DATA_W-1:0] sig_q;
    logic [STIM_DATA_W-1:0] sig_d;

    always_comb begin
        sig_d = sig_q;
        if (clr_i) begin
            sig_d = '0;
        end else if (en_i) begin
            sig_d = {sig_q[STIM_DATA_W-2:0], sig_q[STIM_DATA_W-1]} ^ data_i;
`ifdef STIM_PROBE_EN
            sig_d = sig_d ^ {64'b0, probe_i};
`endif
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sig_q <= '0;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign sig_o = sig_q;

endmodule

// File: rtl/stim_drive_misr.sv
// rtl/stim_drive_misr.sv - LFSR stimulus driver and MISR responder for the fuzzed DUT (option: STIM_PROBE_EN)
module stim_drive_misr
    import stim_pkg::*;
#(
    parameter int                     DRAIN_STEPS = 4,
    parameter int                     CNT_W       = 16,
    parameter logic [STIM_LFSR_W-1:0] POLY        = STIM_POLY_DEFAULT
) (
    input  logic                    clkin,
    input  logic                    rst_n,
    input  logic                    start_i,
    input  logic [STIM_LFSR_W-1:0]  seed_i,
    input  logic [CNT_W-1:0]        num_steps_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic [STIM_CLKIN_W-1:0] clkin_data_o,
    output logic [STIM_DATA_W-1:0]  in_data_o,
    input  logic [STIM_DATA_W-1:0]  out_data_i,
    input  logic [31:0]             probe_data_i,
    output logic [STIM_DATA_W-1:0]  signature_o
);

    localparam logic [CNT_W-1:0] CNT_ONE        = CNT_W'(1);
    localparam logic [CNT_W-1:0] DRAIN_LAST_CNT = CNT_W'(DRAIN_STEPS - 1);

    stim_state_e              state_q, state_d;
    logic                     phase_q, phase_d;
    logic [STIM_LFSR_W-1:0]   lfsr_q, lfsr_d;
    logic [STIM_DATA_W-1:0]   in_data_q, in_data_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [CNT_W-1:0]         nsteps_q, nsteps_d;

    logic                     misr_clr;
    logic                     misr_en;
    logic [STIM_LFSR_W-1:0]   seed_eff;
    logic [STIM_LFSR_W-1:0]   lfsr_step;

    assign seed_eff  = (seed_i == '0) ? 32'd1 : seed_i;
    assign lfsr_step = stim_lfsr_next(lfsr_q, POLY);

    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        lfsr_d    = lfsr_q;
        in_data_d = in_data_q;
        cnt_d     = cnt_q;
        nsteps_d  = nsteps_q;
        misr_clr  = 1'b0;
        misr_en   = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                phase_d = 1'b0;
                if (start_i) begin
                    lfsr_d   = seed_eff;
                    cnt_d    = '0;
                    nsteps_d = num_steps_i;
                    misr_clr = 1'b1;
                    if (num_steps_i == '0) begin
                        state_d = DONE;
                    end else begin
                        state_d   = RUN;
                        in_data_d = stim_expand(seed_eff);
                    end
                end
            end

            RUN: begin
                phase_d = ~phase_q;
                // Leaving phase 1 closes a step: absorb the DUT response, then advance.
                if (phase_q) begin
                    misr_en = 1'b1;
                    if (cnt_q == (nsteps_q - CNT_ONE)) begin
                        cnt_d   = '0;
                        state_d = (DRAIN_STEPS == 0) ? DONE : DRAIN;
                    end else begin
                        cnt_d     = cnt_q + CNT_ONE;
                        lfsr_d    = lfsr_step;
                        in_data_d = stim_expand(lfsr_step);
                    end
                end
            end

            DRAIN: begin
                phase_d = ~phase_q;
                if (phase_q) begin
                    misr_en = 1'b1;
                    if (cnt_q == DRAIN_LAST_CNT) begin
                        cnt_d   = '0;
                        state_d = DONE;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
            end

            default: begin
                state_d = IDLE;
                phase_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            phase_q   <= 1'b0;
            lfsr_q    <= 32'd1;
            in_data_q <= '0;
            cnt_q     <= '0;
            nsteps_q  <= '0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            lfsr_q    <= lfsr_d;
            in_data_q <= in_data_d;
            cnt_q     <= cnt_d;
            nsteps_q  <= nsteps_d;
        end
    end

    misr96 u_misr (
        .clk_i   (clkin),
        .rst_ni  (rst_n),
        .clr_i   (misr_clr),
        .en_i    (misr_en),
        .data_i  (out_data_i),
`ifdef STIM_PROBE_EN
        .probe_i (probe_data_i),
`endif
        .sig_o   (signature_o)
    );

`ifndef STIM_PROBE_EN
    logic unused_probe;
    assign unused_probe = ^probe_data_i;
`endif

    assign busy_o       = (state_q == RUN) || (state_q == DRAIN);
    assign done_o       = (state_q == DONE);
    assign clkin_data_o = {{(STIM_CLKIN_W-1){1'b0}}, phase_q};
    assign in_data_o    = in_data_q;

endmodule

// File: tb/tb_stim_drive_misr.sv
// tb/tb_stim_drive_misr.sv - self-checking bench: time-indexed reference model plus directed literal checks
module tb_stim_drive_misr;

    localparam int D  = 1;
    localparam int CW = 4;

    localparam logic [95:0] LIT_STEP1 = 96'h00000001_A5A5A5A4_FFFFFFFE;
    localparam logic [95:0] LIT_STEP2 = 96'h80200003_2585A5A6_7FDFFFFC;
`ifdef STIM_PROBE_EN
    localparam logic [95:0] LIT_PROBE_SIG = 96'h11;
`else
    localparam logic [95:0] LIT_PROBE_SIG = 96'h0;
`endif

    logic          clkin        = 1'b0;
    logic          rst_n        = 1'b0;
    logic          start_i      = 1'b0;
    logic [31:0]   seed_i       = '0;
    logic [CW-1:0] num_steps_i  = '0;
    logic [95:0]   out_data_i   = '0;
    logic [31:0]   probe_data_i = '0;
    logic          busy_o;
    logic          done_o;
    logic [159:0]  clkin_data_o;
    logic [95:0]   in_data_o;
    logic [95:0]   signature_o;

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    always #5 clkin = ~clkin;

    stim_drive_misr #(.DRAIN_STEPS(D), .CNT_W(CW)) u_dut (
        .clkin        (clkin),
        .rst_n        (rst_n),
        .start_i      (start_i),
        .seed_i       (seed_i),
        .num_steps_i  (num_steps_i),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .clkin_data_o (clkin_data_o),
        .in_data_o    (in_data_o),
        .out_data_i   (out_data_i),
        .probe_data_i (probe_data_i),
        .signature_o  (signature_o)
    );

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: the n-th stimulus word is the seed advanced n-1 times.
    function automatic logic [31:0] m_lfsr_at(input logic [31:0] seed, input int step);
        logic [31:0] v;
        v = seed;
        for (int i = 1; i < step; i++) begin
            if (v % 2 == 1) v = (v / 2) ^ 32'h80200003;
            else            v = v / 2;
        end
        return v;
    endfunction

    function automatic logic [95:0] m_expand(input logic [31:0] v);
        return {v, v ^ 32'hA5A5A5A5, ~v};
    endfunction

    logic        m_run   = 1'b0;
    logic        m_done  = 1'b0;
    int          m_k     = 0;
    int          m_total = 0;
    int          m_n     = 0;
    logic [31:0] m_seed  = 32'd1;
    logic [95:0] m_in    = '0;
    logic [95:0] m_sig   = '0;
    logic [95:0] m_probe;

`ifdef STIM_PROBE_EN
    assign m_probe = {64'b0, probe_data_i};
`else
    assign m_probe = '0;
`endif

    // m_k counts host cycles since the accepted start; odd m_k means the DUT clock is high.
    always @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            m_run  = 1'b0;
            m_done = 1'b0;
            m_k    = 0;
            m_in   = '0;
            m_sig  = '0;
        end else if (m_run) begin
            if (m_k % 2 == 1)
                m_sig = ((m_sig << 1) | (m_sig >> 95)) ^ out_data_i ^ m_probe;
            m_k++;
            if (m_k == m_total) begin
                m_run  = 1'b0;
                m_done = 1'b1;
            end else if (m_k % 2 == 0 && (m_k / 2 + 1) <= m_n) begin
                m_in = m_expand(m_lfsr_at(m_seed, m_k / 2 + 1));
            end
        end else if (start_i) begin
            m_seed = (seed_i == 0) ? 32'd1 : seed_i;
            m_n    = int'(num_steps_i);
            m_sig  = '0;
            m_done = 1'b0;
            if (m_n == 0) begin
                m_done = 1'b1;
            end else begin
                m_run   = 1'b1;
                m_k     = 0;
                m_total = 2 * (m_n + D);
                m_in    = m_expand(m_seed);
            end
        end
    end

    always @(negedge clkin) begin
        if (chk_en) begin
            chk("busy", 160'(busy_o), 160'(m_run));
            chk("done", 160'(done_o), 160'(m_done));
            chk("clkin_data", clkin_data_o, 160'(m_run && (m_k % 2 == 1)));
            chk("in_data", 160'(in_data_o), 160'(m_in));
            chk("signature", 160'(signature_o), 160'(m_sig));
        end
    end

    task automatic do_start(input logic [31:0] s, input logic [CW-1:0] n);
        @(negedge clkin);
        start_i     = 1'b1;
        seed_i      = s;
        num_steps_i = n;
        @(negedge clkin);
        start_i     = 1'b0;
    endtask

    task automatic wait_done();
        int i;
        i = 0;
        while (!done_o && i < 200) begin
            @(negedge clkin);
            i++;
        end
        chk("wait_done", 160'(done_o), 160'(1));
    endtask

    initial begin
        repeat (3) @(negedge clkin);
        rst_n  = 1'b1;
        chk_en = 1'b1;

        repeat (10) @(negedge clkin);
        chk("idle_busy", 160'(busy_o), 160'(0));
        chk("idle_done", 160'(done_o), 160'(0));
        chk("idle_clkin", clkin_data_o, 160'(0));
        chk("idle_in", 160'(in_data_o), 160'(0));
        chk("idle_sig", 160'(signature_o), 160'(0));

        do_start(32'd1, CW'(2));
        chk("seed1_step1", 160'(in_data_o), 160'(LIT_STEP1));
        repeat (2) @(negedge clkin);
        chk("seed1_step2", 160'(in_data_o), 160'(LIT_STEP2));
        wait_done();

        out_data_i = 96'h1;
        do_start(32'd5, CW'(1));
        repeat (3) @(negedge clkin);
        chk("n1_done_early", 160'(done_o), 160'(0));
        @(negedge clkin);
        chk("n1_done_at4", 160'(done_o), 160'(1));
        chk("n1_sig", 160'(signature_o), 160'(96'h3));

        do_start(32'd9, CW'(0));
        chk("n0_done", 160'(done_o), 160'(1));
        chk("n0_sig", 160'(signature_o), 160'(0));
        repeat (4) @(negedge clkin);
        chk("n0_clk_quiet", clkin_data_o, 160'(0));

        do_start(32'd0, CW'(3));
        chk("seed0_step1", 160'(in_data_o), 160'(LIT_STEP1));
        repeat (4) @(negedge clkin);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_busy", 160'(busy_o), 160'(0));
        chk("rst_clkin", clkin_data_o, 160'(0));
        chk("rst_in", 160'(in_data_o), 160'(0));
        chk("rst_sig", 160'(signature_o), 160'(0));
        @(negedge clkin);
        #1 rst_n = 1'b1;
        do_start(32'd1, CW'(3));
        chk("restart_step1", 160'(in_data_o), 160'(LIT_STEP1));
        wait_done();

        out_data_i   = '0;
        probe_data_i = 32'hF;
        do_start(32'd7, CW'(1));
        wait_done();
        chk("probe_sig", 160'(signature_o), 160'(LIT_PROBE_SIG));
        probe_data_i = '0;

        do_start(32'd3, CW'(15));
        for (int k = 1; k <= 32; k++) begin
            @(negedge clkin);
            out_data_i = {$urandom, $urandom, $urandom};
            if (k == 5) begin
                start_i     = 1'b1;
                seed_i      = 32'd99;
                num_steps_i = CW'(2);
            end else begin
                start_i = 1'b0;
            end
            if (k == 31) chk("nmax_done_early", 160'(done_o), 160'(0));
            if (k == 32) chk("nmax_done", 160'(done_o), 160'(1));
        end
        repeat (3) @(negedge clkin);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
